fredkin_descrambler: RTL and testbench
======================================

// Module: fredkin_descrambler
// PURPOSE
//  Receive-side inverse of the controlled-swap (Fredkin) word scrambler. Each accepted word is
//  unscrambled by two layers of cswap cells keyed by an LFSR that runs in lockstep with the
//  transmitter. Sits between the link receiver and the payload consumer; valid/ready on both sides.
// PARAMETERS
//  WIDTH  8      data word width; even, >=4; also LFSR width
//  SEED   8'h01  LFSR value loaded on sync; must be nonzero
//  TAPS   8'hB8  Galois LFSR feedback mask (right-shifting)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_data    in   WIDTH  scrambled word
//  in_sync    in   1      qualifies in_data as first word of a frame (reseed)
//  in_valid   in   1      input word valid
//  in_ready   out  1      block can accept a word
//  out_data   out  WIDTH  unscrambled word
//  out_valid  out  1      output word valid
//  out_ready  in   1      consumer accepts output
//  locked     out  1      1 after first sync word accepted
//  word_cnt   out  16     words emitted since last sync (wraps 16'hFFFF->0)
//  drop_cnt   out  8      words discarded while unlocked (saturates at 8'hFF)
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, locked=0, word_cnt=0, drop_cnt=0, lfsr=SEED, state=HUNT.
//  - Accept = in_valid & in_ready; in_ready = !out_valid | out_ready (one output register, no skid).
//  - Key k for a word: layer0 bits k[WIDTH/2-1:0], layer1 bits k[WIDTH-1:WIDTH/2].
//    layer0 pair j: bits (2j, 2j+1); layer1 pair j: bits (2j+1, (2j+2) mod WIDTH); key bit 1 = swap.
//    Transmitter applies layer0 then layer1; descrambler applies layer1 then layer0.
//  - Key sequence: sync word uses SEED; each later accepted word uses step(previous key).
//    step(s) = s[0] ? (s>>1)^TAPS : s>>1. LFSR advances only on accept in RUN (or sync).
//  - FSM HUNT: accept with in_sync=0 -> word dropped, drop_cnt++ (sat), no output.
//    accept with in_sync=1 -> decode with SEED, lfsr<=step(SEED), locked<=1, -> RUN.
//  - FSM RUN: accept, in_sync=0 -> decode with lfsr, lfsr<=step(lfsr).
//    accept, in_sync=1 -> reseed: decode with SEED, lfsr<=step(SEED), word_cnt restarts.
//  - Latency 1 cycle: decoded word appears in out_data/out_valid on the edge after accept.
//    out_data held stable while out_valid & !out_ready.
//  - word_cnt: sync word loads 1; other emitted words +1, wrap at 16 bits.
//  - Simultaneous output pop and input accept in same cycle: both occur, full throughput.
//  - rst mid-frame: outstanding output discarded, lfsr=SEED, back to HUNT, counters cleared.
//  - in_valid while !in_ready: word not consumed, LFSR and counters unchanged.
// STRUCTURE
//  - Package fredkin_pkg: lfsr_step function, layer-pairing index functions, FSM state enum
//    (HUNT, RUN); shared with the transmit-side scrambler.
//  - Sub-module cswap_layer (WIDTH, ODD_PAIRING): purely combinational bank of WIDTH/2 cswap
//    cells; instantiated twice (odd layer feeding even layer). Top holds FSM, LFSR, regs, counters.
// TESTING  (WIDTH=8, SEED=8'h01, TAPS=8'hB8)
//  1. rst, then in_data=8'h01 in_sync=1 valid -> next cycle out_data=8'h02, locked=1, word_cnt=1.
//  2. 3 words in_sync=0 before any sync -> no out_valid, drop_cnt=3, locked=0.
//  3. Bench scrambler model, 300 random words after sync, random out_ready stalls -> output
//     equals original stream in order, word_cnt=300, no loss or duplication.
//  4. Sync, 5 words, second sync mid-stream -> sync word decoded with key 8'h01, word_cnt=1.
//  5. out_ready=0 for 4 cycles with data pending -> in_ready=0, out_data stable, LFSR frozen.
//  6. rst asserted with out_valid=1 -> next cycle out_valid=0, locked=0, counters 0, HUNT.

Source files
------------

// File: rtl/fredkin_pkg.sv
// Shared definitions for the Fredkin (controlled-swap) scrambler/descrambler pair.
package fredkin_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Right-shifting Galois step; callers zero-extend and truncate to their width.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] taps);
        return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

    function automatic int pair_lo(input int j, input bit odd);
        return odd ? (2 * j + 1) : (2 * j);
    endfunction

    function automatic int pair_hi(input int j, input bit odd, input int w);
        return odd ? ((2 * j + 2) % w) : (2 * j + 1);
    endfunction

endpackage

// File: rtl/fredkin_descrambler_cswap_layer.sv
// One combinational layer of WIDTH/2 controlled-swap cells.
module cswap_layer
    import fredkin_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter bit ODD_PAIRING = 1'b0
) (
    input  logic [WIDTH-1:0]   data_i,
    input  logic [WIDTH/2-1:0] key_i,
    output logic [WIDTH-1:0]   data_o
);

    for (genvar j = 0; j < WIDTH / 2; j++) begin : g_cell
        localparam int LO = pair_lo(j, ODD_PAIRING);
        localparam int HI = pair_hi(j, ODD_PAIRING, WIDTH);

        assign data_o[LO] = key_i[j] ? data_i[HI] : data_i[LO];
        assign data_o[HI] = key_i[j] ? data_i[LO] : data_i[HI];
    end

endmodule

// File: rtl/fredkin_descrambler.sv
// Receive-side Fredkin descrambler: LFSR-keyed two-layer cswap inverse with
// frame sync hunting and a single valid/ready output register.
module fredkin_descrambler
    import fredkin_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sync,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             locked,
    output logic [15:0]      word_cnt,
    output logic [7:0]       drop_cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             locked_q, locked_d;
    logic [15:0]      word_cnt_q, word_cnt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic             accept;
    logic             emit;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] key_next;
    logic [WIDTH-1:0] mid;
    logic [WIDTH-1:0] dec;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign emit     = accept && (in_sync || (state_q == RUN));
    assign key      = in_sync ? SEED : lfsr_q;
    assign key_next = WIDTH'(lfsr_step(32'(key), 32'(TAPS)));

    // Undo the transmitter's order: odd layer first, then even layer.
    cswap_layer #(
        .WIDTH       (WIDTH),
        .ODD_PAIRING (1'b1)
    ) u_layer1 (
        .data_i (in_data),
        .key_i  (key[WIDTH-1:WIDTH/2]),
        .data_o (mid)
    );

    cswap_layer #(
        .WIDTH       (WIDTH),
        .ODD_PAIRING (1'b0)
    ) u_layer0 (
        .data_i (mid),
        .key_i  (key[WIDTH/2-1:0]),
        .data_o (dec)
    );

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        locked_d    = locked_q;
        word_cnt_d  = word_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;

        unique case (state_q)
            HUNT: if (accept && in_sync) state_d = RUN;
            RUN:  state_d = RUN;
        endcase

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = dec;
            lfsr_d      = key_next;
            locked_d    = 1'b1;
            word_cnt_d  = in_sync ? 16'd1 : word_cnt_q + 16'd1;
        end else if (accept && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            lfsr_q      <= SEED;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            word_cnt_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            locked_q    <= locked_d;
            word_cnt_q  <= word_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign locked    = locked_q;
    assign word_cnt  = word_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fredkin_descrambler.sv
// Self-checking bench for fredkin_descrambler against a transmit-side
// scrambler model and a key-sequence model.
module tb_fredkin_descrambler;

    localparam logic [7:0] SEED = 8'h01;
    localparam logic [7:0] TAPS = 8'hB8;
    localparam int         N    = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_sync;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        locked;
    logic [15:0] word_cnt;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int passes = 0;

    fredkin_descrambler dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sync   (in_sync),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .locked    (locked),
        .word_cnt  (word_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] step(input logic [7:0] k);
        return k[0] ? ((k >> 1) ^ TAPS) : (k >> 1);
    endfunction

    function automatic logic [7:0] swap_bits(input logic [7:0] r, input int a, input int b);
        logic [7:0] diff;
        diff = ((r >> a) ^ (r >> b)) & 8'h01;
        return (diff != 8'h00) ? (r ^ ((8'h01 << a) | (8'h01 << b))) : r;
    endfunction

    // Transmitter: even-pair layer keyed by low nibble, then odd-pair layer by high nibble.
    function automatic logic [7:0] scramble(input logic [7:0] d, input logic [7:0] k);
        logic [7:0] r;
        r = d;
        for (int j = 0; j < 4; j++)
            if (((k >> j) & 8'h01) != 8'h00) r = swap_bits(r, 2 * j, 2 * j + 1);
        for (int j = 0; j < 4; j++)
            if (((k >> (4 + j)) & 8'h01) != 8'h00) r = swap_bits(r, 2 * j + 1, (2 * j + 2) % 8);
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sync   = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input logic s);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sync  = s;
        @(negedge clk);
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sync   = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else passes++;
        checks++;
        if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data);
        else passes++;
        checks++;
        if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked);
        else passes++;
        checks++;
        if (word_cnt !== 16'd0 || drop_cnt !== 8'd0)
            $display("FAIL reset_counters: got %0d/%0d want 0/0", word_cnt, drop_cnt);
        else passes++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else passes++;
    endtask

    task automatic test_first_sync();
        do_reset();
        send_word(8'h01, 1'b1);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h02)
            $display("FAIL first_sync_data: got v=%b %h want v=1 02", out_valid, out_data);
        else passes++;
        checks++;
        if (locked !== 1'b1 || word_cnt !== 16'd1)
            $display("FAIL first_sync_state: got locked=%b cnt=%0d want 1/1", locked, word_cnt);
        else passes++;
    endtask

    task automatic test_hunt_drop();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_word(8'($urandom), 1'b0);
            #1;
            checks++;
            if (out_valid !== 1'b0) $display("FAIL hunt_no_output: got %b want 0", out_valid);
            else passes++;
        end
        checks++;
        if (drop_cnt !== 8'd3 || locked !== 1'b0 || word_cnt !== 16'd0)
            $display("FAIL hunt_drop3: got drop=%0d locked=%b cnt=%0d want 3/0/0",
                     drop_cnt, locked, word_cnt);
        else passes++;
        @(negedge clk);
        in_valid = 1'b1;
        in_sync  = 1'b0;
        for (int i = 0; i < 260; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (drop_cnt !== 8'hFF || out_valid !== 1'b0)
            $display("FAIL drop_saturate: got drop=%h v=%b want FF/0", drop_cnt, out_valid);
        else passes++;
    endtask

    task automatic test_resync();
        logic [7:0] k;
        logic [7:0] d;
        do_reset();
        k = SEED;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) k = step(k);
            d = 8'($urandom);
            send_word(scramble(d, k), i == 0);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== d)
                $display("FAIL resync_pre_word%0d: got v=%b %h want v=1 %h",
                         i, out_valid, out_data, d);
            else passes++;
        end
        checks++;
        if (word_cnt !== 16'd6) $display("FAIL resync_pre_cnt: got %0d want 6", word_cnt);
        else passes++;
        d = 8'($urandom);
        send_word(scramble(d, SEED), 1'b1);
        #1;
        checks++;
        if (out_data !== d || word_cnt !== 16'd1 || locked !== 1'b1)
            $display("FAIL resync_sync: got %h cnt=%0d locked=%b want %h 1 1",
                     out_data, word_cnt, locked, d);
        else passes++;
        d = 8'($urandom);
        send_word(scramble(d, step(SEED)), 1'b0);
        #1;
        checks++;
        if (out_data !== d || word_cnt !== 16'd2)
            $display("FAIL resync_after: got %h cnt=%0d want %h 2", out_data, word_cnt, d);
        else passes++;
    endtask

    task automatic test_stall();
        logic [7:0] a;
        logic [7:0] b;
        do_reset();
        a = 8'($urandom);
        b = 8'($urandom);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sync   = 1'b1;
        in_data   = scramble(a, SEED);
        @(negedge clk);
        in_sync = 1'b0;
        in_data = scramble(b, step(SEED));
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== a || word_cnt !== 16'd1)
                $display("FAIL stall_cycle%0d: got rdy=%b v=%b %h cnt=%0d want 0 1 %h 1",
                         i, in_ready, out_valid, out_data, word_cnt, a);
            else passes++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== b || word_cnt !== 16'd2)
            $display("FAIL stall_release: got v=%b %h cnt=%0d want 1 %h 2",
                     out_valid, out_data, word_cnt, b);
        else passes++;
    endtask

    task automatic test_stream();
        logic [7:0] exp_q[$];
        logic [7:0] k;
        logic [7:0] cur;
        logic [7:0] want;
        logic       pending;
        int         sent;
        int         got;
        int         cycles;
        do_reset();
        pending = 1'b0;
        sent    = 0;
        got     = 0;
        cycles  = 0;
        k       = SEED;
        cur     = 8'h00;
        while (got < N && cycles < 20000) begin
            @(negedge clk);
            if (!pending && sent < N && $urandom_range(0, 3) != 0) begin
                cur     = 8'($urandom);
                k       = (sent == 0) ? SEED : step(k);
                pending = 1'b1;
                in_data = scramble(cur, k);
                in_sync = (sent == 0);
            end
            in_valid  = pending;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra: got %h with nothing outstanding", out_data);
                end else begin
                    want = exp_q.pop_front();
                    if (out_data !== want)
                        $display("FAIL stream_word%0d: got %h want %h", got, out_data, want);
                    else passes++;
                end
                got++;
            end
            if (pending && in_ready) begin
                exp_q.push_back(cur);
                sent++;
                pending = 1'b0;
            end
            cycles++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_sync   = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (got !== N || sent !== N || exp_q.size() != 0)
            $display("FAIL stream_complete: got %0d sent %0d left %0d want %0d",
                     got, sent, exp_q.size(), N);
        else passes++;
        checks++;
        if (word_cnt !== 16'(N)) $display("FAIL stream_word_cnt: got %0d want %0d", word_cnt, N);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        do_reset();
        d = 8'($urandom);
        @(negedge clk);
        out_ready = 1'b0;
        send_word(scramble(d, SEED), 1'b1);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== d)
            $display("FAIL rstmid_setup: got v=%b %h want 1 %h", out_valid, out_data, d);
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || locked !== 1'b0)
            $display("FAIL rstmid_out: got v=%b %h locked=%b want 0 00 0",
                     out_valid, out_data, locked);
        else passes++;
        checks++;
        if (word_cnt !== 16'd0 || drop_cnt !== 8'd0)
            $display("FAIL rstmid_counters: got %0d/%0d want 0/0", word_cnt, drop_cnt);
        else passes++;
        out_ready = 1'b1;
        send_word(8'($urandom), 1'b0);
        #1;
        checks++;
        if (out_valid !== 1'b0 || drop_cnt !== 8'd1)
            $display("FAIL rstmid_hunt: got v=%b drop=%0d want 0 1", out_valid, drop_cnt);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_first_sync();
        test_hunt_drop();
        test_resync();
        test_stall();
        test_stream();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
